attention_row_engine: RTL and testbench
=======================================

// Module: attention_row_engine
// PURPOSE
//  Computes one query row of single-head ReLU-normalised attention: s_j = Q.K_j for j < seq_len.
//  Weights are p_j = sat_u(s_j >>> score_shift), clamped to [0, 2^(DW-1)-1].
//  Output is out[d] = sat_s(round(sum_j p_j*V_j[d] >>> out_shift)).
//  Sits in exec_unit/attention; K and V live in external 1-cycle-latency BRAMs, addressed by this block.
// PARAMETERS
//  M   166  max sequence length (K/V rows)
//  N   44   head dimension (lanes per row)
//  DW  8    signed element width of Q/K/V/out
// PORTS
//  clk          in   1        clock
//  rst_n        in   1        async active-low reset
//  start        in   1        launch one row; accepted only in IDLE
//  busy         out  1        high in every state except IDLE
//  seq_len      in   clog2(M+1)  active keys; sampled at start; values >M clamp to M
//  q_idx        in   clog2(M)    query row index; sampled at start; echoed on out_idx
//  score_shift  in   5        arithmetic right shift applied to raw scores; sampled at start
//  out_shift    in   5        requant shift applied to accumulators; sampled at start
//  q_in         in   N*DW     query row; latched at start
//  k_addr       out  clog2(M) K BRAM read address
//  k_data       in   N*DW     K row, valid the cycle after k_addr
//  v_addr       out  clog2(M) V BRAM read address
//  v_data       in   N*DW     V row, valid the cycle after v_addr
//  out_valid    out  1        result row valid; held until out_ready
//  out_ready    in   1        consumer accept
//  out_idx      out  clog2(M) latched q_idx
//  out_data     out  N*DW     result row
// BEHAVIOUR
//  Reset values: busy=0, out_valid=0, out_data=0, out_idx=0, k_addr=0, v_addr=0.
//  All state returns to IDLE. Reset mid-row aborts the row; no partial output is produced.
//  IDLE -> SCORE on start. Inputs are latched, j=0, and k_addr=0 is issued.
//  If the effective length L==0, IDLE goes directly to OUT instead, with all accumulators at 0.
//  SCORE: issue k_addr=j for j=0..L-1 on consecutive cycles.
//   - One cycle later, s = sum over N lanes of signed DW x DW products, at full width 2*DW+clog2(N).
//   - p = min(max(s >>> score_shift, 0), 2^(DW-1)-1). p is written to the internal score buffer [0..M-1].
//   - SCORE lasts L+1 cycles; on the last write, go to ATTN with j=0 and v_addr=0.
//  ATTN: issue v_addr=j for j=0..L-1.
//   - One cycle later, acc[d] += p_j * V_j[d] for all N lanes in parallel.
//   - acc is signed, width 2*DW+clog2(M)+1. ATTN lasts L+1 cycles, then goes to OUT.
//  OUT: out_data[d] = sat to [-2^(DW-1), 2^(DW-1)-1] of (acc[d] + (out_shift ? 1<<(out_shift-1) : 0)) >>> out_shift.
//   - out_valid is asserted the cycle after entering OUT.
//   - out_data and out_idx are stable while out_valid && !out_ready.
//   - On out_valid && out_ready: out_valid=0 and the FSM goes to IDLE.
//   - A start in that same cycle is ignored (busy is still 1).
//  Latency from start to out_valid: 2L+4 cycles for L>=1; 2 cycles for L==0.
//  start while busy is ignored. k_addr/v_addr hold their last value outside SCORE/ATTN.
// CONFIGURATION
//  Macro ATTN_CAUSAL_MASK_EN.
//  Defined: the effective length is L = min(seq_len_clamped, q_idx+1), so keys j>q_idx are never read or accumulated.
//  Undefined: q_idx only feeds out_idx, and L = clamped seq_len.
// STRUCTURE
//  Package attn_pkg: state_t {IDLE, SCORE, ATTN, OUT}, DW-dependent width localparams,
//  and functions sat_signed()/sat_unsigned().
//  Sub-module attn_requant (shift, round-half-up, saturate; parameter IN_W, OUT_W, SIGNED_OUT).
//  It is instantiated once for the score path and N times for the output lanes.
// TESTING
//  1. M=8, N=4, L=1, Q=K=V=[1,1,1,1], shifts=0 -> s=4, p=4, out=[4,4,4,4]; out_valid at cycle 6 after start.
//  2. Q=[127]*N, K=[127]*N, score_shift=0 -> p saturates to 127. K=[-1]*N -> p=0; that V row contributes nothing.
//  3. V=[-128]*N, p=127, L=8, out_shift=0 -> out=-128 (saturated). out_shift=10 gives round(-130048/1024)=-127.
//  4. seq_len=0 -> out_valid 2 cycles after start, out_data=0. seq_len=200 -> treated as M; addresses never exceed M-1.
//  5. Hold out_ready=0 for 5 cycles, pulse start meanwhile -> data held, start ignored. Reset mid-ATTN -> busy=0 next cycle.
//  6. With ATTN_CAUSAL_MASK_EN, q_idx=2, seq_len=8 -> only rows 0..2 read, latency 2*3+4=10 cycles.

Source files
------------

// File: rtl/attn_pkg.sv
// ---------------------------------------------------------------------------
// attn_pkg
//   Shared types and helpers for the attention row engine.
//   - state_t      : FSM state encoding of the row engine.
//   - ELEM_W       : default signed element width of Q/K/V/out.
//   - SAT_W        : working width of the saturation helpers.
//   - sat_signed   : clamp to [-2^(w-1), 2^(w-1)-1].
//   - sat_unsigned : clamp to [0, 2^w-1].
// ---------------------------------------------------------------------------
package attn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCORE = 2'd1,
        ATTN  = 2'd2,
        OUT   = 2'd3
    } state_t;

    localparam int ELEM_W = 8;
    localparam int SAT_W  = 64;

    function automatic logic signed [SAT_W-1:0] sat_signed(
        input logic signed [SAT_W-1:0] v,
        input int                      w
    );
        logic signed [SAT_W-1:0] hi_s;
        logic signed [SAT_W-1:0] lo_s;
        hi_s = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo_s = -(64'sd1 <<< (w - 1));
        if (v > hi_s) begin
            return hi_s;
        end else if (v < lo_s) begin
            return lo_s;
        end else begin
            return v;
        end
    endfunction

    function automatic logic signed [SAT_W-1:0] sat_unsigned(
        input logic signed [SAT_W-1:0] v,
        input int                      w
    );
        logic signed [SAT_W-1:0] hi_s;
        hi_s = (64'sd1 <<< w) - 64'sd1;
        if (v > hi_s) begin
            return hi_s;
        end else if (v < 64'sd0) begin
            return 64'sd0;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/attn_requant.sv
// ---------------------------------------------------------------------------
// attn_requant
//   Combinational requantiser: arithmetic right shift of a two's-complement
//   value, optional round-half-up, then saturation.
//   Parameters:
//     IN_W       input width (two's complement)
//     OUT_W      output width
//     SIGNED_OUT 1: clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1]
//                0: clamp to [0, 2^(OUT_W-1)-1] (non-negative weight in a
//                   signed OUT_W container)
//     ROUND      1: add 2^(shift-1) before shifting; 0: plain floor shift
//                (the score path uses floor, the output lanes round)
//   Ports:
//     x      in  IN_W   value to requantise
//     shift  in  5      right shift amount
//     y      out OUT_W  requantised, saturated value
// ---------------------------------------------------------------------------
module attn_requant
    import attn_pkg::*;
#(
    parameter int IN_W       = 22,
    parameter int OUT_W      = 8,
    parameter bit SIGNED_OUT = 1'b1,
    parameter bit ROUND      = 1'b1
) (
    input  logic [IN_W-1:0]  x,
    input  logic [4:0]       shift,
    output logic [OUT_W-1:0] y
);

    logic signed [SAT_W-1:0] x_ext_s;
    logic signed [SAT_W-1:0] bias_s;
    logic signed [SAT_W-1:0] shifted_s;
    logic signed [SAT_W-1:0] sat_s;
    logic                    sat_hi_unused_s;

    // Shift/round/saturate at 64 bits so a large bias can never wrap.
    always_comb begin
        x_ext_s = {{(SAT_W-IN_W){x[IN_W-1]}}, x};
        if (ROUND && (shift != 5'd0)) begin
            bias_s = 64'sd1 <<< (shift - 5'd1);
        end else begin
            bias_s = 64'sd0;
        end
        shifted_s = (x_ext_s + bias_s) >>> shift;
        if (SIGNED_OUT) begin
            sat_s = sat_signed(shifted_s, OUT_W);
        end else begin
            sat_s = sat_unsigned(shifted_s, OUT_W - 1);
        end
        y               = sat_s[OUT_W-1:0];
        sat_hi_unused_s = ^sat_s[SAT_W-1:OUT_W];
    end

endmodule

// File: rtl/attention_row_engine.sv
// ---------------------------------------------------------------------------
// attention_row_engine
//   One query row of single-head ReLU-normalised attention.
//     s_j    = Q . K_j                        (j < L)
//     p_j    = clamp(s_j >>> score_shift, 0, 2^(DW-1)-1)
//     out[d] = sat_s(round(sum_j p_j*V_j[d] >>> out_shift))
//   K and V are read from external BRAMs with 1-cycle read latency.
//   Optional build macro ATTN_CAUSAL_MASK_EN: when defined, the effective
//   length is min(clamped seq_len, q_idx+1); otherwise q_idx only feeds out_idx.
//   Ports:
//     clk, rst_n            clock, async active-low reset
//     start / busy          launch (IDLE only) / engine occupied
//     seq_len, q_idx        row length and query index, sampled at start
//     score_shift,out_shift shifts, sampled at start
//     q_in                  query row, latched at start
//     k_addr/k_data         K BRAM address / data (data valid next cycle)
//     v_addr/v_data         V BRAM address / data (data valid next cycle)
//     out_valid/out_ready   result handshake; out_idx/out_data held while stalled
// ---------------------------------------------------------------------------
module attention_row_engine
    import attn_pkg::*;
#(
    parameter int M  = 166,
    parameter int N  = 44,
    parameter int DW = ELEM_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic                   busy,
    input  logic [$clog2(M+1)-1:0] seq_len,
    input  logic [$clog2(M)-1:0]   q_idx,
    input  logic [4:0]             score_shift,
    input  logic [4:0]             out_shift,
    input  logic [N*DW-1:0]        q_in,
    output logic [$clog2(M)-1:0]   k_addr,
    input  logic [N*DW-1:0]        k_data,
    output logic [$clog2(M)-1:0]   v_addr,
    input  logic [N*DW-1:0]        v_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(M)-1:0]   out_idx,
    output logic [N*DW-1:0]        out_data
);

    localparam int LW     = $clog2(M+1);
    localparam int ADDR_W = $clog2(M);
    localparam int SW     = 2*DW + $clog2(N);
    localparam int ACC_W  = 2*DW + $clog2(M) + 1;
    localparam logic [LW:0] ONE_X = {{LW{1'b0}}, 1'b1};

    state_t              state_r;
    state_t              state_nxt_s;
    logic                busy_r;
    logic [LW-1:0]       len_in_s;
    logic [LW-1:0]       len_r;
    logic [LW-1:0]       cnt_r;
    logic [LW:0]         cnt_nxt_x;
    logic [LW-1:0]       cnt_dec_s;
    logic                cnt_last_s;
    logic                issue_more_s;
    logic [ADDR_W-1:0]   buf_idx_s;
    logic [N*DW-1:0]     q_r;
    logic [ADDR_W-1:0]   q_idx_r;
    logic [4:0]          score_shift_r;
    logic [4:0]          out_shift_r;
    logic [ADDR_W-1:0]   k_addr_r;
    logic [ADDR_W-1:0]   v_addr_r;
    logic                out_valid_r;
    logic [ADDR_W-1:0]   out_idx_r;
    logic [N*DW-1:0]     out_data_r;
    logic [ACC_W-1:0]    acc_r [N];
    logic [DW-1:0]       score_buf_r [M];
    logic signed [2*DW-1:0] q_prod_s;
    logic [SW-1:0]       score_sum_s;
    logic [DW-1:0]       p_s;
    logic [DW-1:0]       p_cur_s;
    logic signed [2*DW-1:0] v_prod_s [N];
    logic [N*DW-1:0]     lane_out_s;

    // Effective row length of the pending request: clamp to M (and to q_idx+1 when causal).
    always_comb begin
        if (seq_len > LW'(M)) begin
            len_in_s = LW'(M);
        end else begin
            len_in_s = seq_len;
        end
`ifdef ATTN_CAUSAL_MASK_EN
        if ((LW'(q_idx) + ONE_X[LW-1:0]) < len_in_s) begin
            len_in_s = LW'(q_idx) + ONE_X[LW-1:0];
        end else begin
            len_in_s = len_in_s;
        end
`endif
    end

    // Phase counter helpers: cnt runs 0..L in SCORE and ATTN; data for row cnt-1 returns at cnt.
    always_comb begin
        cnt_nxt_x    = {1'b0, cnt_r} + ONE_X;
        cnt_dec_s    = cnt_r - ONE_X[LW-1:0];
        cnt_last_s   = (cnt_r == len_r);
        issue_more_s = (cnt_nxt_x < {1'b0, len_r});
        if (cnt_r != {LW{1'b0}}) begin
            buf_idx_s = ADDR_W'(cnt_dec_s);
        end else begin
            buf_idx_s = {ADDR_W{1'b0}};
        end
    end

    // Raw score: full-width signed dot product of the latched query and the returning K row.
    always_comb begin
        score_sum_s = {SW{1'b0}};
        q_prod_s    = {(2*DW){1'b0}};
        for (int d = 0; d < N; d++) begin
            q_prod_s    = signed'(q_r[d*DW +: DW]) * signed'(k_data[d*DW +: DW]);
            score_sum_s = score_sum_s + {{(SW-2*DW){q_prod_s[2*DW-1]}}, q_prod_s};
        end
    end

    attn_requant #(
        .IN_W       (SW),
        .OUT_W      (DW),
        .SIGNED_OUT (1'b0),
        .ROUND      (1'b0)
    ) u_score_rq (
        .x     (score_sum_s),
        .shift (score_shift_r),
        .y     (p_s)
    );

    // Weighted V lanes: p of row cnt-1 (always non-negative) times the returning V row.
    always_comb begin
        p_cur_s = score_buf_r[buf_idx_s];
        for (int d = 0; d < N; d++) begin
            v_prod_s[d] = signed'(p_cur_s) * signed'(v_data[d*DW +: DW]);
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_lane
        attn_requant #(
            .IN_W       (ACC_W),
            .OUT_W      (DW),
            .SIGNED_OUT (1'b1),
            .ROUND      (1'b1)
        ) u_out_rq (
            .x     (acc_r[g]),
            .shift (out_shift_r),
            .y     (lane_out_s[g*DW +: DW])
        );
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (len_in_s == {LW{1'b0}}) begin
                        state_nxt_s = OUT;
                    end else begin
                        state_nxt_s = SCORE;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SCORE: begin
                if (cnt_last_s) begin
                    state_nxt_s = ATTN;
                end else begin
                    state_nxt_s = SCORE;
                end
            end
            ATTN: begin
                if (cnt_last_s) begin
                    state_nxt_s = OUT;
                end else begin
                    state_nxt_s = ATTN;
                end
            end
            OUT: begin
                if (out_valid_r && out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = OUT;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register and registered busy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != IDLE);
        end
    end

    // Datapath: request latch, address issue, accumulation and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_r         <= {LW{1'b0}};
            cnt_r         <= {LW{1'b0}};
            q_r           <= {(N*DW){1'b0}};
            q_idx_r       <= {ADDR_W{1'b0}};
            score_shift_r <= 5'd0;
            out_shift_r   <= 5'd0;
            k_addr_r      <= {ADDR_W{1'b0}};
            v_addr_r      <= {ADDR_W{1'b0}};
            out_valid_r   <= 1'b0;
            out_idx_r     <= {ADDR_W{1'b0}};
            out_data_r    <= {(N*DW){1'b0}};
            for (int d = 0; d < N; d++) begin
                acc_r[d] <= {ACC_W{1'b0}};
            end
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        len_r         <= len_in_s;
                        cnt_r         <= {LW{1'b0}};
                        q_r           <= q_in;
                        q_idx_r       <= q_idx;
                        score_shift_r <= score_shift;
                        out_shift_r   <= out_shift;
                        for (int d = 0; d < N; d++) begin
                            acc_r[d] <= {ACC_W{1'b0}};
                        end
                        if (len_in_s != {LW{1'b0}}) begin
                            k_addr_r <= {ADDR_W{1'b0}};
                        end
                    end
                end
                SCORE: begin
                    cnt_r <= cnt_last_s ? {LW{1'b0}} : cnt_nxt_x[LW-1:0];
                    if (issue_more_s) begin
                        k_addr_r <= ADDR_W'(cnt_nxt_x);
                    end
                    if (cnt_last_s) begin
                        v_addr_r <= {ADDR_W{1'b0}};
                    end
                end
                ATTN: begin
                    cnt_r <= cnt_last_s ? {LW{1'b0}} : cnt_nxt_x[LW-1:0];
                    if (issue_more_s) begin
                        v_addr_r <= ADDR_W'(cnt_nxt_x);
                    end
                    if (cnt_r != {LW{1'b0}}) begin
                        for (int d = 0; d < N; d++) begin
                            acc_r[d] <= acc_r[d] + {{(ACC_W-2*DW){v_prod_s[d][2*DW-1]}}, v_prod_s[d]};
                        end
                    end
                end
                OUT: begin
                    if (!out_valid_r) begin
                        out_valid_r <= 1'b1;
                        out_data_r  <= lane_out_s;
                        out_idx_r   <= q_idx_r;
                    end else if (out_ready) begin
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    cnt_r <= {LW{1'b0}};
                end
            endcase
        end
    end

    // Score buffer: p of key cnt-1 is written the cycle its K row returns.
    always_ff @(posedge clk) begin
        if ((state_r == SCORE) && (cnt_r != {LW{1'b0}})) begin
            score_buf_r[buf_idx_s] <= p_s;
        end
    end

    assign busy      = busy_r;
    assign k_addr    = k_addr_r;
    assign v_addr    = v_addr_r;
    assign out_valid = out_valid_r;
    assign out_idx   = out_idx_r;
    assign out_data  = out_data_r;

endmodule

// File: tb/tb_attention_row_engine.sv
module tb_attention_row_engine;

    localparam int M  = 8;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int LW = $clog2(M+1);
    localparam int AW = $clog2(M);

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic            busy;
    logic [LW-1:0]   seq_len;
    logic [AW-1:0]   q_idx;
    logic [4:0]      score_shift;
    logic [4:0]      out_shift;
    logic [N*DW-1:0] q_in;
    logic [AW-1:0]   k_addr;
    logic [N*DW-1:0] k_data;
    logic [AW-1:0]   v_addr;
    logic [N*DW-1:0] v_data;
    logic            out_valid;
    logic            out_ready;
    logic [AW-1:0]   out_idx;
    logic [N*DW-1:0] out_data;

    logic [N*DW-1:0] kmem [M];
    logic [N*DW-1:0] vmem [M];
    logic [N*DW-1:0] cur_q;
    int              cur_qi;
    longint          exp_out [N];
    int              n_checks = 0;
    int              n_errors = 0;

    attention_row_engine #(.M(M), .N(N), .DW(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .busy        (busy),
        .seq_len     (seq_len),
        .q_idx       (q_idx),
        .score_shift (score_shift),
        .out_shift   (out_shift),
        .q_in        (q_in),
        .k_addr      (k_addr),
        .k_data      (k_data),
        .v_addr      (v_addr),
        .v_data      (v_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_idx     (out_idx),
        .out_data    (out_data)
    );

    always #5 clk = ~clk;

    // 1-cycle-latency K/V memories
    always @(posedge clk) begin
        k_data <= kmem[k_addr];
        v_data <= vmem[v_addr];
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint lane(input logic [N*DW-1:0] row, input int d);
        logic signed [DW-1:0] e;
        e = row[d*DW +: DW];
        return longint'(e);
    endfunction

    function automatic logic [N*DW-1:0] fill_row(input int v);
        logic [N*DW-1:0] r;
        for (int d = 0; d < N; d++) r[d*DW +: DW] = DW'(v);
        return r;
    endfunction

    function automatic logic [N*DW-1:0] rand_row();
        logic [N*DW-1:0] r;
        for (int d = 0; d < N; d++) r[d*DW +: DW] = DW'($urandom);
        return r;
    endfunction

    function automatic int eff_len(input int sl);
        int l;
        l = (sl > M) ? M : sl;
`ifdef ATTN_CAUSAL_MASK_EN
        if (cur_qi + 1 < l) l = cur_qi + 1;
`endif
        return l;
    endfunction

    // Reference: plain integer arithmetic straight from the attention formulas.
    function automatic void model(input int L, input int ss, input int os);
        longint acc [N];
        longint s, p, t, bias;
        longint pmax, omax, omin;
        pmax = (longint'(1) << (DW-1)) - 1;
        omax = pmax;
        omin = -(longint'(1) << (DW-1));
        for (int d = 0; d < N; d++) acc[d] = 0;
        for (int j = 0; j < L; j++) begin
            s = 0;
            for (int d = 0; d < N; d++) s += lane(cur_q, d) * lane(kmem[j], d);
            p = s >>> ss;
            if (p < 0) p = 0;
            if (p > pmax) p = pmax;
            for (int d = 0; d < N; d++) acc[d] += p * lane(vmem[j], d);
        end
        bias = (os == 0) ? 0 : (longint'(1) << (os - 1));
        for (int d = 0; d < N; d++) begin
            t = (acc[d] + bias) >>> os;
            if (t > omax) t = omax;
            if (t < omin) t = omin;
            exp_out[d] = t;
        end
    endfunction

    task automatic run_row(input string tag, input int sl, input int qi,
                           input int ss, input int os, input int hold);
        int L, lat, exp_lat, kmax, vmax;
        cur_qi  = qi;
        L       = eff_len(sl);
        model(L, ss, os);
        exp_lat = (L == 0) ? 2 : 2*L + 4;
        @(negedge clk);
        seq_len = LW'(sl); q_idx = AW'(qi); score_shift = 5'(ss); out_shift = 5'(os);
        q_in = cur_q; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1; kmax = 0; vmax = 0;
        while (!out_valid && lat < 200) begin
            if (int'(k_addr) > kmax) kmax = int'(k_addr);
            if (lat >= L + 2 && int'(v_addr) > vmax) vmax = int'(v_addr);
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, lat, exp_lat);
        if (L > 0) begin
            check({tag, "_kaddr_max"}, kmax, L - 1);
            check({tag, "_vaddr_max"}, vmax, L - 1);
        end
        for (int d = 0; d < N; d++) check({tag, "_lane"}, lane(out_data, d), exp_out[d]);
        check({tag, "_idx"}, out_idx, qi);
        // Stall with out_ready low; a start pulse in the middle must be ignored.
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            start = (h == 1); q_idx = AW'(qi + 1); seq_len = LW'(1);
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, out_valid, 1);
            check({tag, "_hold_idx"}, out_idx, qi);
            for (int d = 0; d < N; d++) check({tag, "_hold_lane"}, lane(out_data, d), exp_out[d]);
        end
        // Accept, with a simultaneous start that must also be ignored.
        @(negedge clk);
        out_ready = 1'b1; start = 1'b1; seq_len = LW'(1);
        @(posedge clk); #1;
        out_ready = 1'b0; start = 1'b0;
        check({tag, "_ack_valid"}, out_valid, 0);
        check({tag, "_ack_busy"}, busy, 0);
        @(posedge clk); #1;
        check({tag, "_post_busy"}, busy, 0);
    endtask

    initial begin
        int vcount;
        rst_n = 1'b0; start = 1'b0; out_ready = 1'b0;
        seq_len = '0; q_idx = '0; score_shift = 5'd0; out_shift = 5'd0; q_in = '0;
        cur_q = '0; cur_qi = 0;
        for (int j = 0; j < M; j++) begin kmem[j] = '0; vmem[j] = '0; end
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_valid", out_valid, 0);
        check("rst_data", longint'(out_data), 0);
        check("rst_idx", out_idx, 0);
        check("rst_kaddr", k_addr, 0);
        check("rst_vaddr", v_addr, 0);
        @(negedge clk); rst_n = 1'b1;

        // All ones, one key
        cur_q = fill_row(1); kmem[0] = fill_row(1); vmem[0] = fill_row(1);
        run_row("ones", 1, 0, 0, 0, 0);
        for (int d = 0; d < N; d++) check("ones_const", lane(out_data, d), 4);

        // Score saturates high for key 0, clamps to zero for key 1
        cur_q = fill_row(127); kmem[0] = fill_row(127); kmem[1] = fill_row(-1);
        vmem[0] = rand_row(); vmem[1] = rand_row();
        run_row("psat", 2, 7, 0, 3, 0);

        // Output saturation and rounding with V = -128 everywhere
        for (int j = 0; j < M; j++) begin kmem[j] = fill_row(127); vmem[j] = fill_row(-128); end
        run_row("osat", 8, 7, 0, 0, 0);
        check("osat_const", lane(out_data, 0), -128);
        run_row("oround", 8, 7, 0, 10, 0);
        check("oround_const", lane(out_data, N - 1), -127);

        // Empty row and over-long row
        run_row("empty", 0, 3, 0, 4, 0);
        check("empty_const", longint'(out_data), 0);
        for (int j = 0; j < M; j++) begin kmem[j] = rand_row(); vmem[j] = rand_row(); end
        cur_q = rand_row();
        run_row("clamp", 15, 7, 6, 5, 0);

        // Back-pressure with start pulses
        run_row("stall", 3, 5, 4, 3, 5);

        // Query index 2 with eight keys (masked to three when causal)
        run_row("causal", 8, 2, 5, 6, 0);

        // Reset in the middle of ATTN
        @(negedge clk);
        seq_len = LW'(8); q_idx = AW'(7); q_in = cur_q; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("midrst_busy_before", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_valid", out_valid, 0);
        check("midrst_kaddr", k_addr, 0);
        @(negedge clk); rst_n = 1'b1;
        vcount = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (out_valid) vcount++;
        end
        check("midrst_no_output", vcount, 0);
        check("midrst_idle", busy, 0);

        // Randomised rows
        for (int r = 0; r < 20; r++) begin
            for (int j = 0; j < M; j++) begin kmem[j] = rand_row(); vmem[j] = rand_row(); end
            cur_q = rand_row();
            run_row("rand", $urandom_range(0, 15), $urandom_range(0, 7),
                    $urandom_range(0, 10), $urandom_range(0, 14), $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
